// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   rob_type_e   : entry kinds (ROB_REG, ROB_STORE, ROB_BRANCH), matching the issueType encoding
//   rob_entry_t  : per-entry bookkeeping, apart from the destination register whose width
//                  is a parameter of the top level
//   DEPTH        : entry count of the default configuration
package rob_pkg;

    localparam int unsigned ROB_WIDTH_DEFAULT = 4;
    localparam int unsigned DEPTH             = 1 << ROB_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        ROB_REG    = 2'b00,
        ROB_STORE  = 2'b01,
        ROB_BRANCH = 2'b10
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic        pred_taken;
        logic [31:0] alt_pc;
        logic [31:0] value;   // result; for a branch, bit 0 is the actual direction
    } rob_entry_t;

endpackage

// File: rtl/rob_query_port.sv
// One operand lookup port of the reorder buffer.
//   entry_ready_i / entry_value_i : busy&ready flag and stored value of every entry
//   rs_* / lsb_*                  : result broadcasts of the current cycle
//   query_index_i                 : entry being looked up
//   query_ready_o / query_val_o   : lookup result, purely combinational
// Optional feature (macro ROB_QUERY_BYPASS_EN): a same-cycle broadcast to the queried index
// is forwarded, the load/store broadcast taking priority. Without it only stored state is
// visible, so a broadcast shows up one cycle later.
module rob_query_port #(
    parameter int unsigned ROB_WIDTH   = 4,
    parameter int unsigned NUM_ENTRIES = 16
) (
    input  logic [NUM_ENTRIES-1:0]       entry_ready_i,
    input  logic [NUM_ENTRIES-1:0][31:0] entry_value_i,
    input  logic                         rs_update_i,
    input  logic [ROB_WIDTH-1:0]         rs_index_i,
    input  logic [31:0]                  rs_val_i,
    input  logic                         lsb_update_i,
    input  logic [ROB_WIDTH-1:0]         lsb_index_i,
    input  logic [31:0]                  lsb_val_i,
    input  logic [ROB_WIDTH-1:0]         query_index_i,
    output logic                         query_ready_o,
    output logic [31:0]                  query_val_o
);

`ifdef ROB_QUERY_BYPASS_EN
    always_comb begin
        if (lsb_update_i && (lsb_index_i == query_index_i)) begin
            query_ready_o = 1'b1;
            query_val_o   = lsb_val_i;
        end else if (rs_update_i && (rs_index_i == query_index_i)) begin
            query_ready_o = 1'b1;
            query_val_o   = rs_val_i;
        end else begin
            query_ready_o = entry_ready_i[query_index_i];
            query_val_o   = entry_value_i[query_index_i];
        end
    end
`else
    assign query_ready_o = entry_ready_i[query_index_i];
    assign query_val_o   = entry_value_i[query_index_i];

    logic unused_bcast;
    assign unused_bcast = ^{rs_update_i, rs_index_i, rs_val_i,
                            lsb_update_i, lsb_index_i, lsb_val_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue.
//   clockIn/resetIn       : clock and asynchronous active-low reset
//   issue*                : allocate an entry at the tail; issueRobIndex is the index it gets
//   full                  : count >= DEPTH-1 (one slot of slack for a same-cycle issue)
//   rs*/lsb*              : result broadcasts marking entries ready (lsb wins on a tie)
//   query*                : two combinational operand lookups (see rob_query_port)
//   commit*               : registered REG retirement
//   store*                : registered STORE release
//   clear/clearPc         : registered flush on a mispredicted branch
// Optional feature: ROB_QUERY_BYPASS_EN enables same-cycle broadcast forwarding in queries.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [REG_WIDTH-1:0] issueDest,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueRobIndex,
    output logic                 full,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] queryIndex1,
    input  logic [ROB_WIDTH-1:0] queryIndex2,
    output logic                 queryReady1,
    output logic                 queryReady2,
    output logic [31:0]          queryVal1,
    output logic [31:0]          queryVal2,
    output logic                 commitValid,
    output logic [REG_WIDTH-1:0] commitReg,
    output logic [31:0]          commitVal,
    output logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic                 storeCommit,
    output logic [ROB_WIDTH-1:0] storeRobIndex,
    output logic                 clear,
    output logic [31:0]          clearPc
);

    localparam int unsigned        NUM_ENTRIES = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] CNT_ONE     = {{ROB_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH:0] CNT_DEPTH   = NUM_ENTRIES[ROB_WIDTH:0];
    localparam logic [ROB_WIDTH:0] CNT_FULL    = CNT_DEPTH - CNT_ONE;

    rob_entry_t           entries_q [NUM_ENTRIES];
    rob_entry_t           entries_d [NUM_ENTRIES];
    logic [REG_WIDTH-1:0] dest_q    [NUM_ENTRIES];
    logic [REG_WIDTH-1:0] dest_d    [NUM_ENTRIES];
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_valid_q, commit_valid_d;
    logic [REG_WIDTH-1:0] commit_reg_q, commit_reg_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic [ROB_WIDTH-1:0] commit_idx_q, commit_idx_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_idx_q, store_idx_d;
    logic                 clear_q, clear_d;
    logic [31:0]          clear_pc_q, clear_pc_d;

    rob_entry_t head_entry;
    logic       retire, mispredict, issue_ok;

    assign head_entry = entries_q[head_q];
    assign retire     = head_entry.busy & head_entry.ready;
    assign mispredict = retire && (head_entry.kind == ROB_BRANCH) &&
                        (head_entry.value[0] != head_entry.pred_taken);
    assign issue_ok   = issueValid && (count_q < CNT_DEPTH);

    always_comb begin
        entries_d      = entries_q;
        dest_d         = dest_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_reg_d   = commit_reg_q;
        commit_val_d   = commit_val_q;
        commit_idx_d   = commit_idx_q;
        store_commit_d = 1'b0;
        store_idx_d    = store_idx_q;
        clear_d        = 1'b0;
        clear_pc_d     = clear_pc_q;

        if (mispredict) begin
            // Flush wins over everything else this cycle, including issue and writebacks.
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            clear_d    = 1'b1;
            clear_pc_d = head_entry.alt_pc;
        end else begin
            // rs first so that lsb overrides it on the same index.
            if (rsUpdate && entries_q[rsRobIndex].busy) begin
                entries_d[rsRobIndex].ready = 1'b1;
                entries_d[rsRobIndex].value = rsVal;
            end
            if (lsbUpdate && entries_q[lsbRobIndex].busy) begin
                entries_d[lsbRobIndex].ready = 1'b1;
                entries_d[lsbRobIndex].value = lsbVal;
            end
            if (issue_ok) begin
                entries_d[tail_q].busy       = 1'b1;
                entries_d[tail_q].ready      = 1'b0;
                entries_d[tail_q].kind       = rob_type_e'(issueType);
                entries_d[tail_q].pred_taken = issuePredTaken;
                entries_d[tail_q].alt_pc     = issueAltPc;
                dest_d[tail_q]               = issueDest;
                tail_d                       = tail_q + ROB_WIDTH'(1);
            end
            if (retire) begin
                entries_d[head_q].busy  = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d                  = head_q + ROB_WIDTH'(1);
                case (head_entry.kind)
                    ROB_REG: begin
                        commit_valid_d = 1'b1;
                        commit_reg_d   = dest_q[head_q];
                        commit_val_d   = head_entry.value;
                        commit_idx_d   = head_q;
                    end
                    ROB_STORE: begin
                        store_commit_d = 1'b1;
                        store_idx_d    = head_q;
                    end
                    default: ;  // correctly predicted branch retires silently
                endcase
            end
            count_d = count_q + (issue_ok ? CNT_ONE : '0) - (retire ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= rob_entry_t'('0);
                dest_q[i]    <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_q   <= '0;
            commit_val_q   <= '0;
            commit_idx_q   <= '0;
            store_commit_q <= 1'b0;
            store_idx_q    <= '0;
            clear_q        <= 1'b0;
            clear_pc_q     <= '0;
        end else begin
            entries_q      <= entries_d;
            dest_q         <= dest_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_q   <= commit_reg_d;
            commit_val_q   <= commit_val_d;
            commit_idx_q   <= commit_idx_d;
            store_commit_q <= store_commit_d;
            store_idx_q    <= store_idx_d;
            clear_q        <= clear_d;
            clear_pc_q     <= clear_pc_d;
        end
    end

    logic [NUM_ENTRIES-1:0]       entry_ready;
    logic [NUM_ENTRIES-1:0][31:0] entry_value;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            entry_ready[i] = entries_q[i].busy & entries_q[i].ready;
            entry_value[i] = entries_q[i].value;
        end
    end

    rob_query_port #(
        .ROB_WIDTH   (ROB_WIDTH),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_query1 (
        .entry_ready_i (entry_ready),
        .entry_value_i (entry_value),
        .rs_update_i   (rsUpdate),
        .rs_index_i    (rsRobIndex),
        .rs_val_i      (rsVal),
        .lsb_update_i  (lsbUpdate),
        .lsb_index_i   (lsbRobIndex),
        .lsb_val_i     (lsbVal),
        .query_index_i (queryIndex1),
        .query_ready_o (queryReady1),
        .query_val_o   (queryVal1)
    );

    rob_query_port #(
        .ROB_WIDTH   (ROB_WIDTH),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_query2 (
        .entry_ready_i (entry_ready),
        .entry_value_i (entry_value),
        .rs_update_i   (rsUpdate),
        .rs_index_i    (rsRobIndex),
        .rs_val_i      (rsVal),
        .lsb_update_i  (lsbUpdate),
        .lsb_index_i   (lsbRobIndex),
        .lsb_val_i     (lsbVal),
        .query_index_i (queryIndex2),
        .query_ready_o (queryReady2),
        .query_val_o   (queryVal2)
    );

    assign issueRobIndex  = tail_q;
    assign full           = (count_q >= CNT_FULL);
    assign commitValid    = commit_valid_q;
    assign commitReg      = commit_reg_q;
    assign commitVal      = commit_val_q;
    assign commitRobIndex = commit_idx_q;
    assign storeCommit    = store_commit_q;
    assign storeRobIndex  = store_idx_q;
    assign clear          = clear_q;
    assign clearPc        = clear_pc_q;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue downstream of the reservation station and load/store buffer; consumes their broadcast results (robIndex + value).
- Allocates one entry per issued instruction and retires from the head in program order: register writes, store-release pulses, branch-resolution checks.
- On a mispredicted branch it flushes the whole machine.
- Also answers two combinational operand queries from the instruction unit.

Parameters:
- ROB_WIDTH, 4, log2 of entry count (DEPTH = 2**ROB_WIDTH)
- REG_WIDTH, 5, architectural register index width

Ports:
- clockIn  input  1  clock, rising edge
- resetIn  input  1  asynchronous, active-low reset
- issueValid  input  1  allocate entry at tail this cycle
- issueType  input  2  00 REG write, 01 STORE, 10 BRANCH
- issueDest  input  REG_WIDTH  destination register (REG only)
- issuePredTaken  input  1  predicted direction (BRANCH only)
- issueAltPc  input  32  PC to resume at if prediction wrong
- issueRobIndex  output  ROB_WIDTH  current tail index, the index the issued entry receives
- full  output  1  count >= DEPTH-1
- rsUpdate / rsRobIndex / rsVal  input  1/ROB_WIDTH/32  ALU result broadcast
- lsbUpdate / lsbRobIndex / lsbVal  input  1/ROB_WIDTH/32  load result or store-address-ready broadcast
- queryIndex1, queryIndex2  input  ROB_WIDTH  operand lookup
- queryReady1, queryReady2  output  1  entry has value
- queryVal1, queryVal2  output  32  entry value
- commitValid  output  1  REG entry retired
- commitReg  output  REG_WIDTH  register written
- commitVal  output  32  value written
- commitRobIndex  output  ROB_WIDTH  retired index (register file clears tag if it matches)
- storeCommit  output  1  head STORE retired; LSB may write memory
- storeRobIndex  output  ROB_WIDTH  retired store index
- clear  output  1  flush pulse
- clearPc  output  32  redirect PC

Behaviour:
- Storage: per entry busy, ready, type, dest, predTaken, altPc, value. head, tail, count registers.
- Reset (resetIn low, asynchronous): head = tail = count = 0; all busy/ready = 0; every output register 0 (commitValid, storeCommit, clear, and all index/data outputs).
- Issue: if issueValid and count < DEPTH, write entry at tail (busy = 1, ready = 0) and increment tail mod DEPTH. Issue at count == DEPTH is dropped.
- Writeback: rsUpdate marks entry rsRobIndex ready with value rsVal; lsbUpdate does the same with lsbVal. Writeback to a non-busy entry is ignored. If both target the same index, lsb wins.
- BRANCH result: bit 0 of the value is the actual taken flag.
- Commit, at most one per cycle, when head busy and ready. Output registers are valid the cycle after the edge that retires:
  - REG: commitValid = 1 with commitReg, commitVal, commitRobIndex.
  - STORE: storeCommit = 1 with storeRobIndex.
  - BRANCH, value[0] == predTaken: retire silently.
  - BRANCH, mismatch: clear = 1, clearPc = altPc. All busy and ready bits cleared, head = tail = count = 0 at that same edge. Issue and writebacks in that cycle are discarded.
- Pulse outputs deassert the following cycle unless a new retire occurs.
- Count update: count += issue accepted − retire. Simultaneous issue and retire leaves count unchanged. Indices wrap modulo DEPTH.
- full is combinational; the one-slot margin absorbs an issue made in the same cycle full rises.
- Query: queryReadyN = busy & ready of the indexed entry; queryValN = that entry's value; purely combinational.

Optional Feature:
- ROB_QUERY_BYPASS_EN defined: queries also match same-cycle rsUpdate/lsbUpdate (lsb priority), returning ready = 1 and the broadcast value.
- Not defined: queries see only stored state, so a broadcast becomes visible one cycle later.

Decomposition:
- Shared package rob_pkg: entry type encodings (ROB_REG, ROB_STORE, ROB_BRANCH), the entry struct typedef, and DEPTH.
- One natural sub-module, rob_query_port, instantiated twice: index mux plus optional bypass compare.

Test Plan:
- Reset mid-operation:
  - Stimulus: issue 3 entries, drop resetIn asynchronously.
  - Response: count = 0; all outputs 0 without waiting for a clock edge; next issue receives issueRobIndex = 0.
- Out-of-order writeback:
  - Stimulus: issue REG r5 (idx 0) and REG r6 (idx 1); rsUpdate idx 1 = 0x22, then idx 0 = 0x11.
  - Response: commit r5 = 0x11, then r6 = 0x22, on consecutive cycles.
- Fill and wrap:
  - Stimulus: issue 15 entries.
  - Response: full = 1 at count 15; the 16th issue in the same cycle is accepted. After retiring 4 and issuing 4, tail wraps to index 3.
- Misprediction flush:
  - Stimulus: BRANCH predTaken = 0, altPc = 0x100, lsb/rs value = 1, followed by two REG entries.
  - Response: clear = 1 and clearPc = 0x100 for one cycle; younger entries are never committed; issueRobIndex = 0 afterwards.
- Correct prediction and store:
  - Stimulus: BRANCH with matching result, then a STORE made ready by lsbUpdate.
  - Response: no clear; storeCommit = 1 with storeRobIndex = 1.
- Query bypass:
  - Stimulus: same-cycle rsUpdate idx 2 = 0xABCD with queryIndex1 = 2.
  - Response: queryReady1 = 1 and queryVal1 = 0xABCD with ROB_QUERY_BYPASS_EN; queryReady1 = 0 without it.
